led_pwm_fader: RTL and testbench

- Output stage downstream of the LED pattern counter; replaces the direct inverted drive of the 6 board LEDs.
- Converts a per-LED on/off target into a PWM brightness level that ramps smoothly toward that target.
- Ramping is paced by the 1-cycle step pulse from the existing timer overflow.
- Drives the active-low board LED pins directly.

---
 rtl/led_pwm_fader.sv | 92 +++++++++
 tb/tb_led_pwm_fader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_fader.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_fader
// Description : Per-LED PWM brightness ramp toward an on/off target, paced by
//               an external step pulse, driving board LED pins directly.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_fader #(
    parameter int NUM_LEDS   = 6,
    parameter int PWM_BITS   = 8,
    parameter int STEP       = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step,
    input  logic [NUM_LEDS-1:0] target,
    output logic [NUM_LEDS-1:0] led_output,
    output logic                pwm_wrap,
    output logic                busy
);

    localparam logic [PWM_BITS-1:0] c_max  = '1;
    localparam logic [PWM_BITS-1:0] c_zero = '0;
    localparam logic [PWM_BITS-1:0] c_one  = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [PWM_BITS:0]   c_step = (PWM_BITS+1)'(STEP);
    localparam logic                c_pol  = (ACTIVE_LOW != 0);
    localparam logic [NUM_LEDS-1:0] c_dark = {NUM_LEDS{c_pol}};

    logic [PWM_BITS-1:0]                r_pwm_cnt;
    logic                               r_pwm_wrap;
    logic [NUM_LEDS-1:0]                r_led;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0]  r_bright;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0]  r_duty;

    logic [NUM_LEDS-1:0][PWM_BITS-1:0]  w_next_bright;
    logic [NUM_LEDS-1:0]                w_on;
    logic [NUM_LEDS-1:0]                w_ne;
    logic                               w_period_end;

    assign w_period_end = (r_pwm_cnt == c_max);

    generate
        for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
            logic [PWM_BITS-1:0] w_tgt;
            logic [PWM_BITS:0]   w_sum;
            logic [PWM_BITS:0]   w_diff;
            logic [PWM_BITS-1:0] w_up;
            logic [PWM_BITS-1:0] w_down;

            assign w_tgt  = target[i] ? c_max : c_zero;
            // Extra MSB catches overflow on the way up and borrow on the way down.
            assign w_sum  = {1'b0, r_bright[i]} + c_step;
            assign w_diff = {1'b0, r_bright[i]} - c_step;
            assign w_up   = w_sum[PWM_BITS]  ? c_max  : w_sum[PWM_BITS-1:0];
            assign w_down = w_diff[PWM_BITS] ? c_zero : w_diff[PWM_BITS-1:0];

            assign w_next_bright[i] = (r_bright[i] < w_tgt) ? w_up   :
                                      (r_bright[i] > w_tgt) ? w_down : r_bright[i];
            assign w_ne[i] = (r_bright[i] != w_tgt);
            // Full-scale duty is forced on so the LED never blinks at cnt==MAX.
            assign w_on[i] = (r_duty[i] == c_max) || (r_pwm_cnt < r_duty[i]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pwm_cnt  <= c_zero;
            r_pwm_wrap <= 1'b0;
            r_led      <= c_dark;
            r_bright   <= '0;
            r_duty     <= '0;
        end else begin
            r_pwm_cnt  <= r_pwm_cnt + c_one;
            r_pwm_wrap <= w_period_end;
            r_led      <= w_on ^ c_dark;
            if (step) begin
                r_bright <= w_next_bright;
            end
            // Duty only changes at the period boundary, so no partial periods.
            if (w_period_end) begin
                r_duty <= r_bright;
            end
        end
    end

    assign led_output = r_led;
    assign pwm_wrap   = r_pwm_wrap;
    assign busy       = |w_ne;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_fader.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pwm_fader
// Description : Directed self-checking bench for led_pwm_fader (STEP=64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pwm_fader;

    logic       clk;
    logic       rst_n;
    logic       step;
    logic [5:0] target;
    logic [5:0] led_output;
    logic       pwm_wrap;
    logic       busy;

    int n_err;
    int n_checks;

    led_pwm_fader #(
        .NUM_LEDS   (6),
        .PWM_BITS   (8),
        .STEP       (64),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (step),
        .target     (target),
        .led_output (led_output),
        .pwm_wrap   (pwm_wrap),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic wait_wrap();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pwm_wrap && n < 300);
        check("wrap_seen", {31'd0, pwm_wrap}, 32'd1);
    endtask

    // Counts lit samples of LED0 and any sample where LEDs 5..1 are not dark.
    task automatic measure(input int cycles, output int lit0, output int other_bad);
        lit0 = 0;
        other_bad = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (led_output[0] == 1'b0) lit0++;
            if (led_output[5:1] != 5'h1F) other_bad++;
        end
    endtask

    initial begin
        int n;
        int lit;
        int bad;
        int up_exp   [5] = '{64, 128, 192, 255, 255};
        int up_busy  [5] = '{1, 1, 1, 0, 0};
        int dn_exp   [4] = '{191, 127, 63, 0};
        int rev_exp  [4] = '{64, 0, 0, 0};
        int rev_busy [4] = '{1, 0, 0, 0};

        n_err    = 0;
        n_checks = 0;
        rst_n    = 1'b0;
        step     = 1'b1;
        target   = 6'h3F;

        // Reset with step and target active; both must be ignored.
        repeat (3) @(negedge clk);
        check("rst_led", {26'd0, led_output}, 32'h3F);
        check("rst_wrap", {31'd0, pwm_wrap}, 32'd0);
        check("rst_bright0", {24'd0, dut.r_bright[0]}, 32'd0);
        check("rst_bright5", {24'd0, dut.r_bright[5]}, 32'd0);

        rst_n  = 1'b1;
        step   = 1'b0;
        target = 6'h00;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pwm_wrap && n < 400);
        check("first_wrap_latency", n, 32'd256);

        // Ramp up LED0 with widely spaced steps.
        target = 6'b000001;
        for (int s = 0; s < 5; s++) begin
            pulse_step();
            check("up_bright", {24'd0, dut.r_bright[0]}, up_exp[s]);
            check("up_busy", {31'd0, busy}, up_busy[s]);
            if (s == 0) begin
                wait_wrap();
                measure(256, lit, bad);
                check("duty64_lit", lit, 32'd64);
                check("duty64_others_dark", bad, 32'd0);
            end else begin
                repeat (299) @(negedge clk);
            end
        end

        // Full scale: no dropout across several periods.
        wait_wrap();
        measure(800, lit, bad);
        check("duty255_lit", lit, 32'd800);
        check("duty255_others_dark", bad, 32'd0);

        // Ramp to zero, then confirm fully dark.
        target = 6'b000000;
        for (int s = 0; s < 4; s++) begin
            pulse_step();
            check("down_bright", {24'd0, dut.r_bright[0]}, dn_exp[s]);
        end
        wait_wrap();
        measure(800, lit, bad);
        check("duty0_lit", lit, 32'd0);

        // Direction reversal mid-ramp.
        target = 6'b000001;
        pulse_step();
        check("rev_up1", {24'd0, dut.r_bright[0]}, 32'd64);
        pulse_step();
        check("rev_up2", {24'd0, dut.r_bright[0]}, 32'd128);
        target = 6'b000000;
        for (int s = 0; s < 4; s++) begin
            pulse_step();
            check("rev_bright", {24'd0, dut.r_bright[0]}, rev_exp[s]);
            check("rev_busy", {31'd0, busy}, rev_busy[s]);
        end

        // Step coinciding with the last counter value of a period.
        target = 6'b000001;
        pulse_step();
        check("coin_pre", {24'd0, dut.r_bright[0]}, 32'd64);
        wait_wrap();
        repeat (255) @(negedge clk);
        check("coin_cnt", {24'd0, dut.r_pwm_cnt}, 32'd255);
        pulse_step();
        check("coin_wrap", {31'd0, pwm_wrap}, 32'd1);
        check("coin_bright", {24'd0, dut.r_bright[0]}, 32'd128);
        measure(256, lit, bad);
        check("coin_period1_lit", lit, 32'd64);
        measure(256, lit, bad);
        check("coin_period2_lit", lit, 32'd128);

        // Reset in the middle of a period at partial brightness.
        pulse_step();
        check("mid_bright", {24'd0, dut.r_bright[0]}, 32'd192);
        wait_wrap();
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_led", {26'd0, led_output}, 32'h3F);
        check("mid_rst_cnt", {24'd0, dut.r_pwm_cnt}, 32'd0);
        check("mid_rst_bright", {24'd0, dut.r_bright[0]}, 32'd0);
        check("mid_rst_wrap", {31'd0, pwm_wrap}, 32'd0);
        check("mid_rst_busy_t1", {31'd0, busy}, 32'd1);
        rst_n  = 1'b1;
        target = 6'b000000;
        #1;
        check("mid_rst_busy_t0", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
